// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the 4-channel bit-interleaved TDM demultiplexer:
//   - state_e : receiver FSM states (HUNT, LOCKED)
//   - NUM_CH  : number of interleaved channels
//   - slot_t  : channel slot index (2 bits)
// -----------------------------------------------------------------------------
package tdm_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    typedef logic [1:0] slot_t;

endpackage : tdm_pkg

// File: rtl/tdm_demux_1x4_chan_shift.sv
// -----------------------------------------------------------------------------
// tdm_chan_shift
// WIDTH-bit MSB-first shift register for one TDM channel. A new bit enters at
// bit 0 and older bits move toward the MSB, so after WIDTH shifts the first
// bit received sits in bit WIDTH-1.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   clr_i    in   discard contents; with shift_i, the bit is loaded into an
//                 otherwise empty register
//   shift_i  in   shift din_i in this cycle
//   din_i    in   serial bit
//   data_o   out  current register contents (WIDTH bits)
// -----------------------------------------------------------------------------
module tdm_chan_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             shift_i,
    input  logic             din_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next-state: clear has priority, but a simultaneous shift still keeps the new bit.
    always_comb begin
        data_d = data_q;
        if (clr_i && shift_i) begin
            data_d = {{(WIDTH-1){1'b0}}, din_i};
        end else if (clr_i) begin
            data_d = {WIDTH{1'b0}};
        end else if (shift_i) begin
            data_d = {data_q[WIDTH-2:0], din_i};
        end else begin
            data_d = data_q;
        end
    end

    // Shift register storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= {WIDTH{1'b0}};
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule : tdm_chan_shift

// File: rtl/tdm_demux_1x4.sv
// -----------------------------------------------------------------------------
// tdm_demux_1x4
// Receive end of a bit-interleaved 4:1 TDM serial link. fsync aligns the block
// to the stream; each qualified bit is steered to channel `slot` (rotating
// 0..3). When the 4*WIDTH-th bit of a frame is sampled, all four words are
// published on ch0..ch3 with a one-cycle out_valid strobe on that same edge.
//
// Optional feature (macro TDM_SYNC_CHECK_EN):
//   defined     : fsync in LOCKED while slot/bitcnt are not both 0 pulses
//                 sync_err, drops the partial frame and restarts the frame at
//                 the current bit.
//   not defined : fsync is only used to leave HUNT; sync_err is tied to 0.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   din        in   serial data bit
//   in_valid   in   din/fsync qualifier; nothing advances when 0
//   fsync      in   marks the first bit of a frame
//   ch0..ch3   out  last completed channel words (WIDTH bits each)
//   out_valid  out  one-cycle strobe: ch0..ch3 updated this cycle
//   locked     out  1 while in LOCKED
//   sync_err   out  one-cycle pulse on misaligned fsync
// -----------------------------------------------------------------------------
module tdm_demux_1x4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             in_valid,
    input  logic             fsync,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic             out_valid,
    output logic             locked,
    output logic             sync_err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] BITCNT_LAST = CW'(WIDTH - 1);

    state_e            state_q, state_d;
    slot_t             slot_q, slot_d;
    logic [CW-1:0]     bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0]  ch_q [NUM_CH];
    logic [WIDTH-1:0]  ch_d [NUM_CH];
    logic              out_valid_q, out_valid_d;
    logic              sync_err_q, sync_err_d;

    logic [WIDTH-1:0]  sr_s [NUM_CH];
    logic [NUM_CH-1:0] shift_en_s;
    logic              clr_s;
    logic              resync_s;

    // Channel shift registers, one per slot.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        tdm_chan_shift #(.WIDTH(WIDTH)) u_shift (
            .clk     (clk),
            .rst     (rst),
            .clr_i   (clr_s),
            .shift_i (shift_en_s[g]),
            .din_i   (din),
            .data_o  (sr_s[g])
        );
    end

`ifdef TDM_SYNC_CHECK_EN
    // Misaligned fsync: anything other than the first bit position of a frame.
    assign resync_s = fsync && ((slot_q != 2'd0) || (bitcnt_q != {CW{1'b0}}));
`else
    assign resync_s = 1'b0;
`endif

    // FSM next-state, slot/bit counters, shift steering and output capture.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        bitcnt_d    = bitcnt_q;
        ch_d        = ch_q;
        out_valid_d = 1'b0;
        sync_err_d  = 1'b0;
        shift_en_s  = {NUM_CH{1'b0}};
        clr_s       = 1'b0;

        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (fsync) begin
                        // First frame bit: start an empty frame in ch0.
                        clr_s         = 1'b1;
                        shift_en_s[0] = 1'b1;
                        slot_d        = 2'd1;
                        bitcnt_d      = {CW{1'b0}};
                        state_d       = LOCKED;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (resync_s) begin
                        // Drop the partial frame; this bit starts a new one.
                        sync_err_d    = 1'b1;
                        clr_s         = 1'b1;
                        shift_en_s[0] = 1'b1;
                        slot_d        = 2'd1;
                        bitcnt_d      = {CW{1'b0}};
                    end else begin
                        shift_en_s[slot_q] = 1'b1;
                        if ((slot_q == 2'd3) && (bitcnt_q == BITCNT_LAST)) begin
                            // ch3 is not yet shifted this cycle, so splice in the final bit.
                            ch_d[0]     = sr_s[0];
                            ch_d[1]     = sr_s[1];
                            ch_d[2]     = sr_s[2];
                            ch_d[3]     = {sr_s[3][WIDTH-2:0], din};
                            out_valid_d = 1'b1;
                            slot_d      = 2'd0;
                            bitcnt_d    = {CW{1'b0}};
                        end else begin
                            slot_d = slot_q + 2'd1;
                            if (slot_q == 2'd3) begin
                                bitcnt_d = bitcnt_q + {{(CW-1){1'b0}}, 1'b1};
                            end else begin
                                bitcnt_d = bitcnt_q;
                            end
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            slot_q      <= 2'd0;
            bitcnt_q    <= {CW{1'b0}};
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            bitcnt_q    <= bitcnt_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_q[i] <= ch_d[i];
            end
        end
    end

    assign ch0       = ch_q[0];
    assign ch1       = ch_q[1];
    assign ch2       = ch_q[2];
    assign ch3       = ch_q[3];
    assign out_valid = out_valid_q;
    assign locked    = (state_q == LOCKED);
    assign sync_err  = sync_err_q;

endmodule : tdm_demux_1x4

// File: tb/tb_tdm_demux_1x4.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux_1x4
// Directed self-checking bench for tdm_demux_1x4 (WIDTH=8). Expectations for
// the misaligned-fsync scenario follow TDM_SYNC_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_tdm_demux_1x4;

    logic       clk;
    logic       rst;
    logic       din;
    logic       in_valid;
    logic       fsync;
    logic [7:0] ch0, ch1, ch2, ch3;
    logic       out_valid;
    logic       locked;
    logic       sync_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    tdm_demux_1x4 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .in_valid  (in_valid),
        .fsync     (fsync),
        .ch0       (ch0),
        .ch1       (ch1),
        .ch2       (ch2),
        .ch3       (ch3),
        .out_valid (out_valid),
        .locked    (locked),
        .sync_err  (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Serial bit k of a frame whose words are packed {ch0,ch1,ch2,ch3}.
    function automatic logic frame_bit(input logic [31:0] words, input int k);
        logic [7:0] w;
        case (k % 4)
            0:       w = words[31:24];
            1:       w = words[23:16];
            2:       w = words[15:8];
            default: w = words[7:0];
        endcase
        return w[7 - (k / 4)];
    endfunction

    // Present one qualified bit; returns #1 after the edge that samples it.
    task automatic send_bit(input logic d, input logic fs);
        @(negedge clk);
        din      = d;
        fsync    = fs;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        fsync    = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        fsync    = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 1'b0; in_valid = 1'b0; fsync = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(10);
        tests_run++;
        if ({ch0, ch1, ch2, ch3} !== 32'h0000_0000) begin
            tests_failed++;
            $display("FAIL reset_ch: got %h expected 00000000", {ch0, ch1, ch2, ch3});
        end
        tests_run++;
        if ({out_valid, locked, sync_err} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got ov/lk/se=%b expected 000", {out_valid, locked, sync_err});
        end
        // Non-fsync bits must be discarded while hunting.
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        tests_run++;
        if (locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL hunt_discard: got locked=%b expected 0", locked);
        end
    endtask

    task automatic test_basic_frame();
        logic [31:0] w = 32'hA5_3C_FF_00;
        int early = 0;
        int start_cyc = 0;
        for (int k = 0; k < 32; k++) begin
            send_bit(frame_bit(w, k), (k == 0));
            if (k == 0) start_cyc = cyc;
            if (k < 31 && out_valid === 1'b1) early++;
        end
        tests_run++;
        if (out_valid !== 1'b1 || early != 0) begin
            tests_failed++;
            $display("FAIL basic_strobe: got out_valid=%b early=%0d expected 1 and 0", out_valid, early);
        end
        tests_run++;
        if ({ch0, ch1, ch2, ch3} !== 32'hA5_3C_FF_00) begin
            tests_failed++;
            $display("FAIL basic_data: got %h expected a53cff00", {ch0, ch1, ch2, ch3});
        end
        tests_run++;
        if (locked !== 1'b1 || (cyc - start_cyc) != 31) begin
            tests_failed++;
            $display("FAIL basic_lock_lat: got locked=%b span=%0d expected 1 and 31", locked, cyc - start_cyc);
        end
        idle(2);
        tests_run++;
        if (out_valid !== 1'b0 || {ch0, ch1, ch2, ch3} !== 32'hA5_3C_FF_00) begin
            tests_failed++;
            $display("FAIL basic_hold: got ov=%b ch=%h expected 0 a53cff00", out_valid, {ch0, ch1, ch2, ch3});
        end
    endtask

    task automatic test_gap_frame();
        logic [31:0] w = 32'hA5_3C_FF_00;
        int pulses = 0;
        int start_cyc = 0;
        int done_cyc = 0;
        for (int k = 0; k < 32; k++) begin
            if (k == 5 || k == 17 || k == 26) begin
                idle(1);
                if (out_valid === 1'b1) pulses++;
            end
            send_bit(frame_bit(w, k), (k == 0));
            if (k == 0) start_cyc = cyc;
            if (out_valid === 1'b1) begin
                pulses++;
                done_cyc = cyc;
            end
        end
        tests_run++;
        if (pulses != 1 || (done_cyc - start_cyc) != 34) begin
            tests_failed++;
            $display("FAIL gap_timing: got pulses=%0d span=%0d expected 1 and 34", pulses, done_cyc - start_cyc);
        end
        tests_run++;
        if ({ch0, ch1, ch2, ch3} !== 32'hA5_3C_FF_00) begin
            tests_failed++;
            $display("FAIL gap_data: got %h expected a53cff00", {ch0, ch1, ch2, ch3});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] f0 = 32'h12_34_56_78;
        logic [31:0] f1 = 32'h9A_BC_DE_F0;
        int pulses = 0;
        int errs = 0;
        int first_cyc = 0;
        int second_cyc = 0;
        logic [31:0] first_data = 32'h0;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 32; k++) begin
                send_bit(frame_bit((f == 0) ? f0 : f1, k), (k == 0));
                if (sync_err === 1'b1) errs++;
                if (out_valid === 1'b1) begin
                    pulses++;
                    if (pulses == 1) begin
                        first_cyc  = cyc;
                        first_data = {ch0, ch1, ch2, ch3};
                    end else begin
                        second_cyc = cyc;
                    end
                end
            end
        end
        tests_run++;
        if (pulses != 2 || (second_cyc - first_cyc) != 32) begin
            tests_failed++;
            $display("FAIL b2b_pulses: got pulses=%0d gap=%0d expected 2 and 32", pulses, second_cyc - first_cyc);
        end
        tests_run++;
        if (first_data !== 32'h12_34_56_78) begin
            tests_failed++;
            $display("FAIL b2b_frame0: got %h expected 12345678", first_data);
        end
        tests_run++;
        if ({ch0, ch1, ch2, ch3} !== 32'h9A_BC_DE_F0 || errs != 0) begin
            tests_failed++;
            $display("FAIL b2b_frame1: got %h errs=%0d expected 9abcdef0 and 0", {ch0, ch1, ch2, ch3}, errs);
        end
    endtask

    task automatic test_misaligned_fsync();
        logic [31:0] x = 32'h11_22_33_44;
        int pulses = 0;
        int errs = 0;
`ifdef TDM_SYNC_CHECK_EN
        logic [31:0] y = 32'h5A_C3_96_69;
        logic err_at_resync = 1'b0;
        for (int k = 0; k < 13; k++) begin
            send_bit(frame_bit(x, k), (k == 0));
            if (out_valid === 1'b1) pulses++;
            if (sync_err === 1'b1) errs++;
        end
        for (int k = 0; k < 32; k++) begin
            send_bit(frame_bit(y, k), (k == 0));
            if (k == 0) err_at_resync = sync_err;
            if (sync_err === 1'b1) errs++;
            if (out_valid === 1'b1 && k != 31) pulses++;
        end
        tests_run++;
        if (err_at_resync !== 1'b1 || errs != 1) begin
            tests_failed++;
            $display("FAIL misalign_err: got pulse=%b count=%0d expected 1 and 1", err_at_resync, errs);
        end
        tests_run++;
        if (pulses != 0 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL misalign_abort: got stray=%0d final_ov=%b expected 0 and 1", pulses, out_valid);
        end
        tests_run++;
        if ({ch0, ch1, ch2, ch3} !== 32'h5A_C3_96_69) begin
            tests_failed++;
            $display("FAIL misalign_data: got %h expected 5ac39669", {ch0, ch1, ch2, ch3});
        end
`else
        for (int k = 0; k < 32; k++) begin
            send_bit(frame_bit(x, k), (k == 0 || k == 13));
            if (sync_err === 1'b1) errs++;
            if (out_valid === 1'b1 && k != 31) pulses++;
        end
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL misalign_err: got count=%0d expected 0", errs);
        end
        tests_run++;
        if (pulses != 0 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL misalign_complete: got stray=%0d final_ov=%b expected 0 and 1", pulses, out_valid);
        end
        tests_run++;
        if ({ch0, ch1, ch2, ch3} !== 32'h11_22_33_44) begin
            tests_failed++;
            $display("FAIL misalign_data: got %h expected 11223344", {ch0, ch1, ch2, ch3});
        end
`endif
        idle(1);
        tests_run++;
        if (sync_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL misalign_err_clear: got %b expected 0", sync_err);
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] z = 32'hDE_AD_BE_EF;
        logic [31:0] v = 32'h0F_1E_2D_3C;
        for (int k = 0; k < 20; k++) begin
            send_bit(frame_bit(z, k), (k == 0));
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if ({ch0, ch1, ch2, ch3} !== 32'h0 || {out_valid, locked, sync_err} !== 3'b000) begin
            tests_failed++;
            $display("FAIL rst_mid_async: got ch=%h flags=%b expected 0 and 000", {ch0, ch1, ch2, ch3}, {out_valid, locked, sync_err});
        end
        @(negedge clk);
        rst = 1'b0;
        // Remaining bits of the interrupted frame must not lock the block.
        for (int k = 20; k < 24; k++) begin
            send_bit(frame_bit(z, k), 1'b0);
        end
        tests_run++;
        if (locked !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_hunt: got locked=%b ov=%b expected 0 0", locked, out_valid);
        end
        for (int k = 0; k < 32; k++) begin
            send_bit(frame_bit(v, k), (k == 0));
        end
        tests_run++;
        if (out_valid !== 1'b1 || {ch0, ch1, ch2, ch3} !== 32'h0F_1E_2D_3C) begin
            tests_failed++;
            $display("FAIL rst_mid_next: got ov=%b ch=%h expected 1 0f1e2d3c", out_valid, {ch0, ch1, ch2, ch3});
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_gap_frame();
        test_back_to_back();
        test_misaligned_fsync();
        test_reset_midframe();
        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_tdm_demux_1x4

// File: doc/tdm_demux_1x4.md
# tdm_demux_1x4

Four-channel time-division demultiplexer: the receive end of a bit-interleaved 4:1 TDM serial link. A frame-sync marker aligns the block to the incoming stream. Each serial bit is steered to one of four channel shift registers by a rotating slot counter. When a full frame has been received, all four WIDTH-bit channel words are presented in parallel with a one-cycle strobe. It sits between the serial link input and the per-channel parallel consumers.

## Interface
- WIDTH, 8, bits per channel word; a frame carries 4*WIDTH bits.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  serial data bit, sampled when in_valid=1.
- in_valid  input  1  din qualifier; no state advances when 0.
- fsync  input  1  frame-start marker; qualified by in_valid; marks the first bit of a frame.
- ch0, ch1, ch2, ch3  output  WIDTH each  last completed channel words.
- out_valid  output  1  one-cycle strobe: ch0..ch3 were updated this cycle.
- locked  output  1  1 in LOCKED state.
- sync_err  output  1  one-cycle pulse on misaligned fsync (see Configuration).

## Operation
- FSM states: HUNT (reset state) and LOCKED.
- HUNT:
  - Bits with fsync=0 are discarded.
  - A bit with in_valid=1 and fsync=1 is stored as bit 0 of ch0, with slot=1 and bitcnt=0. The FSM then moves to LOCKED.
- LOCKED, each qualified bit:
  - The bit shifts into the shift register of channel `slot`, MSB-first, so the first bit of a word ends up in bit WIDTH-1.
  - slot increments modulo 4. When slot wraps 3→0, bitcnt increments.
- Frame completion: on the bit where slot=3 and bitcnt=WIDTH-1, all four assembled words, including this final bit, are copied to ch0..ch3 and out_valid is asserted. slot and bitcnt then return to 0.
- Frame order: frame bit k goes to channel k mod 4, word bit position WIDTH-1-(k div 4).
- Expected fsync is any qualified bit with slot=0 and bitcnt=0 in LOCKED. This is not an error and the block continues normally.
- Misaligned fsync (LOCKED, fsync=1 while slot≠0 or bitcnt≠0): behaviour depends on TDM_SYNC_CHECK_EN.
- ch0..ch3 hold their values between frames. Partial frames never reach the outputs.
- Reset values: ch0..ch3=0, out_valid=0, locked=0, sync_err=0, slot=0, bitcnt=0, state=HUNT.

## Timing
- Outputs are registered. out_valid, the ch* update and sync_err all appear on the clock edge that samples the triggering bit.
- Latency from the last frame bit sampled to out_valid high is 1 clock edge (same edge).
- With in_valid held high, one frame arrives every 4*WIDTH cycles and out_valid pulses once per frame.
- in_valid gaps pause the counters. A frame may span any number of cycles.
- fsync on the edge immediately after a completion edge is the expected case and is valid. It produces no error.
- rst asserted mid-frame clears the partial frame and the outputs asynchronously. After release, the block hunts for fsync again.
- The bitcnt width is $clog2(WIDTH). WIDTH must be at least 2.

## Configuration
- Macro: TDM_SYNC_CHECK_EN.
- Defined, on misaligned fsync:
  - sync_err pulses.
  - The partial frame is discarded.
  - The current bit is taken as bit 0 of ch0 of a new frame: slot=1, bitcnt=0, state stays LOCKED.
  - No out_valid is produced for the aborted frame.
- Not defined:
  - fsync is ignored in LOCKED; it is used only to leave HUNT.
  - sync_err is tied to 0. The port remains present.

## Structure
- A shared package `tdm_pkg` holds:
  - the state enum (HUNT, LOCKED);
  - NUM_CH=4;
  - a slot-index typedef, 2 bits.
- One sub-module, `tdm_chan_shift`, is instantiated 4 times. It is a WIDTH-bit MSB-first shift register with a shift enable and a clear.
- The FSM, the counters and the output registers live in the top module.

## Test plan
- Reset, then 10 idle cycles → all outputs 0, locked=0.
- WIDTH=8: fsync, then 32 interleaved bits for ch0=0xA5, ch1=0x3C, ch2=0xFF, ch3=0x00 → single out_valid pulse carrying exactly these values, locked=1.
- Same frame with in_valid deasserted for 3 cycles at random points → identical outputs, out_valid delayed by 3 cycles.
- Two back-to-back frames (0x12/0x34/0x56/0x78, then 0x9A/0xBC/0xDE/0xF0), fsync on each first bit → two out_valid pulses 32 cycles apart, sync_err=0.
- TDM_SYNC_CHECK_EN defined, fsync at frame bit 13 → sync_err pulses, no out_valid at bit 31. A following clean 32-bit frame from that fsync is output correctly.
- Same stimulus without the macro → sync_err stays 0 and the original frame completes at bit 31. Finally, rst asserted at frame bit 20 → outputs 0, locked=0, and the next frame decodes correctly.
